// File: rtl/fir_tcdm_responder.sv
// fir_tcdm_responder
//   Word-interleaved, multi-bank TCDM slave memory that serves MP master ports.
//   Each bank has its own round-robin arbiter. Grants are issued in the same
//   cycle as the request, and the response follows one cycle later.
//   Optional LFSR-driven grant stalls exercise the masters' back-pressure paths.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   tcdm_req       [MP]     request per port
//   tcdm_gnt       [MP]     grant per port (combinational)
//   tcdm_add       [MP*32]  byte address per port
//   tcdm_wen       [MP]     1 = read, 0 = write
//   tcdm_be        [MP*4]   byte enables (writes only)
//   tcdm_data      [MP*32]  write data
//   tcdm_r_data    [MP*32]  read data (registered)
//   tcdm_r_valid   [MP]     response valid (registered)
module fir_tcdm_responder #(
   parameter int MP             = 4,
   parameter int NB             = 8,
   parameter int WORDS_PER_BANK = 256,
   parameter int STALL_EN       = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [MP-1:0]    tcdm_req,
   output logic [MP-1:0]    tcdm_gnt,
   input  logic [MP*32-1:0] tcdm_add,
   input  logic [MP-1:0]    tcdm_wen,
   input  logic [MP*4-1:0]  tcdm_be,
   input  logic [MP*32-1:0] tcdm_data,
   output logic [MP*32-1:0] tcdm_r_data,
   output logic [MP-1:0]    tcdm_r_valid
);

   localparam int BW = $clog2(NB);
   localparam int AW = $clog2(WORDS_PER_BANK);
   localparam int RW = (MP > 1) ? $clog2(MP) : 1;

   logic [BW-1:0] port_bank_s  [MP];
   logic [AW-1:0] port_row_s   [MP];
   logic [RW-1:0] rr_q         [NB];
   logic [RW-1:0] rr_d         [NB];
   logic          stall_s;
   logic [MP-1:0] gnt_s;
   logic          bank_we_s    [NB];
   logic [AW-1:0] bank_row_s   [NB];
   logic [3:0]    bank_be_s    [NB];
   logic [31:0]   bank_wdata_s [NB];
   logic [31:0]   mem_q        [NB][WORDS_PER_BANK];
   logic [MP-1:0] r_valid_q;
   logic [MP-1:0] r_valid_d;
   logic [31:0]   r_data_q     [MP];
   logic [31:0]   r_data_d     [MP];
   // Byte offset and upper address bits are intentionally ignored (aliasing).
   logic          unused_addr_s;

   assign unused_addr_s = ^tcdm_add;

   // Optional stall generator: 16-bit Fibonacci LFSR, taps 16,14,13,11.
   if (STALL_EN != 0) begin : g_stall
      logic [15:0] lfsr_q;
      logic [15:0] lfsr_d;

      // Next LFSR state: shift right, feedback enters at the top bit.
      always_comb begin
         lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      end

      // LFSR register, reseeded on reset.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            lfsr_q <= 16'hACE1;
         end else begin
            lfsr_q <= lfsr_d;
         end
      end

      assign stall_s = (lfsr_q[1:0] == 2'b11);
   end else begin : g_no_stall
      assign stall_s = 1'b0;
   end

   // Address decode: word-interleaved bank select, row index wraps.
   always_comb begin
      for (int p = 0; p < MP; p++) begin
         port_bank_s[p] = tcdm_add[p*32+2 +: BW];
         port_row_s[p]  = tcdm_add[p*32+2+BW +: AW];
      end
   end

   // Per-bank round-robin arbitration and selection of the bank's write port.
   always_comb begin
      int   p;
      logic hit;
      p     = 0;
      hit   = 1'b0;
      gnt_s = '0;
      for (int b = 0; b < NB; b++) begin
         rr_d[b]         = rr_q[b];
         bank_we_s[b]    = 1'b0;
         bank_row_s[b]   = '0;
         bank_be_s[b]    = 4'b0000;
         bank_wdata_s[b] = 32'h0000_0000;
         hit             = 1'b0;
         // Search upward from the pointer; the first requester wins.
         for (int k = 0; k < MP; k++) begin
            p = (int'(rr_q[b]) + k) % MP;
            if (!hit && !rst_i && !stall_s && tcdm_req[p] &&
                (int'(port_bank_s[p]) == b)) begin
               hit             = 1'b1;
               gnt_s[p]        = 1'b1;
               rr_d[b]         = RW'((p + 1) % MP);
               bank_we_s[b]    = !tcdm_wen[p];
               bank_row_s[b]   = port_row_s[p];
               bank_be_s[b]    = tcdm_be[p*4 +: 4];
               bank_wdata_s[b] = tcdm_data[p*32 +: 32];
            end else begin
               hit = hit;
            end
         end
      end
   end

   // Response capture: reads load the stored word, writes keep old data.
   always_comb begin
      r_valid_d = gnt_s;
      for (int p = 0; p < MP; p++) begin
         if (gnt_s[p] && tcdm_wen[p]) begin
            r_data_d[p] = mem_q[port_bank_s[p]][port_row_s[p]];
         end else begin
            r_data_d[p] = r_data_q[p];
         end
      end
   end

   // Response and arbitration-pointer registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid_q <= '0;
         for (int p = 0; p < MP; p++) begin
            r_data_q[p] <= 32'h0000_0000;
         end
         for (int b = 0; b < NB; b++) begin
            rr_q[b] <= '0;
         end
      end else begin
         r_valid_q <= r_valid_d;
         for (int p = 0; p < MP; p++) begin
            r_data_q[p] <= r_data_d[p];
         end
         for (int b = 0; b < NB; b++) begin
            rr_q[b] <= rr_d[b];
         end
      end
   end

   // Bank storage; not reset. Writes are impossible during reset since
   // every grant is masked by rst_i.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NB; b++) begin
         if (bank_we_s[b]) begin
            for (int k = 0; k < 4; k++) begin
               if (bank_be_s[b][k]) begin
                  mem_q[b][bank_row_s[b]][k*8 +: 8] <= bank_wdata_s[b][k*8 +: 8];
               end
            end
         end
      end
   end

   // Flatten per-port read data onto the output bus.
   always_comb begin
      for (int p = 0; p < MP; p++) begin
         tcdm_r_data[p*32 +: 32] = r_data_q[p];
      end
   end

   assign tcdm_gnt     = gnt_s;
   assign tcdm_r_valid = r_valid_q;

endmodule

// File: tb/tb_fir_tcdm_responder.sv
// Self-checking bench for fir_tcdm_responder.
// dut0: STALL_EN=0, directed + randomized traffic against a word-level memory model.
// dut1: STALL_EN=1, continuous requests on port 0 checked against an LFSR model.
module tb_fir_tcdm_responder;

   localparam int MP   = 4;
   localparam int NB   = 8;
   localparam int WPB  = 256;
   localparam int MEMW = NB * WPB;

   logic         clk = 1'b0;
   logic         rst0, rst1;
   logic [3:0]   req0, gnt0, wen0, rv0;
   logic [3:0]   req1, gnt1, wen1, rv1;
   logic [127:0] add0, data0, rd0;
   logic [127:0] add1, data1, rd1;
   logic [15:0]  be0, be1;

   always #5 clk = ~clk;

   fir_tcdm_responder #(.MP(MP), .NB(NB), .WORDS_PER_BANK(WPB), .STALL_EN(0)) dut0 (
      .clk_i(clk), .rst_i(rst0), .tcdm_req(req0), .tcdm_gnt(gnt0), .tcdm_add(add0),
      .tcdm_wen(wen0), .tcdm_be(be0), .tcdm_data(data0), .tcdm_r_data(rd0), .tcdm_r_valid(rv0));

   fir_tcdm_responder #(.MP(MP), .NB(NB), .WORDS_PER_BANK(WPB), .STALL_EN(1)) dut1 (
      .clk_i(clk), .rst_i(rst1), .tcdm_req(req1), .tcdm_gnt(gnt1), .tcdm_add(add1),
      .tcdm_wen(wen1), .tcdm_be(be1), .tcdm_data(data1), .tcdm_r_data(rd1), .tcdm_r_valid(rv1));

   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] mref [MEMW];
   int          rr_m [NB];
   logic [3:0]  exp_rv0, last_g0;
   logic [31:0] exp_rd0 [MP];
   logic        known0 = 1'b0;
   int          lfsr_m;
   logic        exp_rv1, last_g1, last_s1, obs_g1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic int word_of(input logic [31:0] a);
      return int'(a[31:2]);
   endfunction

   task automatic drive0(input int p, input logic r, input logic [31:0] a, input logic wn,
                         input logic [3:0] b, input logic [31:0] d);
      req0[p] = r;
      add0[p*32 +: 32] = a;
      wen0[p] = wn;
      be0[p*4 +: 4] = b;
      data0[p*32 +: 32] = d;
   endtask

   // One clock of dut0: predict grants, check at negedge, update model at posedge.
   task automatic cycle0();
      logic [3:0] eg;
      int best, bestd, d, w;
      eg = 4'b0000;
      if (!rst0) begin
         for (int b = 0; b < NB; b++) begin
            best = -1;
            bestd = MP;
            for (int p = 0; p < MP; p++) begin
               w = word_of(add0[p*32 +: 32]);
               if (req0[p] && (w % NB) == b) begin
                  d = (p - rr_m[b] + MP) % MP;
                  if (d < bestd) begin
                     bestd = d;
                     best = p;
                  end
               end
            end
            if (best >= 0) eg[best] = 1'b1;
         end
      end
      @(negedge clk);
      chk("gnt0", {28'd0, gnt0}, {28'd0, eg});
      if (known0) begin
         for (int p = 0; p < MP; p++) begin
            chk($sformatf("rvalid0[%0d]", p), {31'd0, rv0[p]}, {31'd0, exp_rv0[p]});
            chk($sformatf("rdata0[%0d]", p), rd0[p*32 +: 32], exp_rd0[p]);
         end
      end
      @(posedge clk);
      if (rst0) begin
         exp_rv0 = 4'b0000;
         for (int p = 0; p < MP; p++) exp_rd0[p] = 32'd0;
         for (int b = 0; b < NB; b++) rr_m[b] = 0;
         known0 = 1'b1;
      end else begin
         exp_rv0 = eg;
         for (int p = 0; p < MP; p++) begin
            w = word_of(add0[p*32 +: 32]);
            if (eg[p] && wen0[p]) exp_rd0[p] = mref[w % MEMW];
         end
         for (int p = 0; p < MP; p++) begin
            w = word_of(add0[p*32 +: 32]);
            if (eg[p]) begin
               rr_m[w % NB] = (p + 1) % MP;
               if (!wen0[p]) begin
                  for (int k = 0; k < 4; k++) begin
                     if (be0[p*4+k]) mref[w % MEMW][k*8 +: 8] = data0[p*32+k*8 +: 8];
                  end
               end
            end
         end
      end
      last_g0 = eg;
      #1;
   endtask

   // One clock of dut1: port 0 only, zero-byte-enable writes keep r_data at 0.
   task automatic cycle1();
      logic es, eg;
      int fb;
      es = ((lfsr_m & 3) == 3);
      eg = !rst1 && req1[0] && !es;
      @(negedge clk);
      chk("stall_gnt", {28'd0, gnt1}, {31'd0, eg});
      chk("stall_rvalid", {28'd0, rv1}, {31'd0, exp_rv1});
      chk("stall_rdata", rd1[31:0], 32'd0);
      obs_g1 = gnt1[0];
      @(posedge clk);
      if (rst1) begin
         lfsr_m = 16'hACE1;
         exp_rv1 = 1'b0;
      end else begin
         exp_rv1 = eg;
         fb = ((lfsr_m >> 0) ^ (lfsr_m >> 2) ^ (lfsr_m >> 3) ^ (lfsr_m >> 5)) & 1;
         lfsr_m = (lfsr_m >> 1) | (fb << 15);
      end
      last_g1 = eg;
      last_s1 = es;
      #1;
   endtask

   initial begin
      int w, k, gcnt, nonstall;
      logic found;
      logic [31:0] a;
      rst0 = 1'b1; rst1 = 1'b1;
      req0 = '0; wen0 = '0; be0 = '0; add0 = '0; data0 = '0;
      req1 = '0; wen1 = '0; be1 = '0; add1 = '0; data1 = '0;
      for (int i = 0; i < MEMW; i++) mref[i] = 32'd0;
      cycle0();
      cycle0();
      rst0 = 1'b0;

      // Basic write then read of 0x100.
      drive0(0, 1'b1, 32'h100, 1'b0, 4'hF, 32'hDEADBEEF);
      cycle0();
      chk("basic_wr_gnt", {31'd0, last_g0[0]}, 32'd1);
      drive0(0, 1'b1, 32'h100, 1'b1, 4'hF, 32'd0);
      cycle0();
      chk("basic_rd_gnt", {31'd0, last_g0[0]}, 32'd1);
      chk("basic_rd_valid", {31'd0, rv0[0]}, 32'd1);
      chk("basic_rd_data", rd0[31:0], 32'hDEADBEEF);
      req0 = '0;
      cycle0();

      // Byte enables.
      drive0(0, 1'b1, 32'h40, 1'b0, 4'hF, 32'h11223344);
      cycle0();
      drive0(0, 1'b1, 32'h40, 1'b0, 4'b0101, 32'hAABBCCDD);
      cycle0();
      drive0(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'd0);
      cycle0();
      chk("be_data", rd0[31:0], 32'h11BB33DD);
      req0 = '0;

      // Preload words 0..31 from port 3 (leaves bank-0 pointer at port 0).
      for (int i = 0; i < 32; i++) begin
         drive0(3, 1'b1, 32'(i * 4), 1'b0, 4'hF, $urandom);
         cycle0();
      end
      req0 = '0;

      // All ports hammer bank 0: strict rotation 0,1,2,3.
      for (int p = 0; p < MP; p++) drive0(p, 1'b1, 32'(p * 32), 1'b1, 4'h0, 32'd0);
      for (int i = 0; i < 12; i++) begin
         cycle0();
         chk("rr_order", {28'd0, last_g0}, 32'd1 << (i % 4));
      end

      // Parallel banks, then aliasing of 0x2000 onto 0x0.
      for (int p = 0; p < MP; p++) drive0(p, 1'b1, 32'(p * 4), 1'b1, 4'h0, 32'd0);
      cycle0();
      chk("par_gnt", {28'd0, last_g0}, 32'hF);
      req0 = '0;
      drive0(1, 1'b1, 32'h2000, 1'b0, 4'hF, 32'h5A5A1234);
      cycle0();
      req0 = '0;
      drive0(2, 1'b1, 32'h0, 1'b1, 4'h0, 32'd0);
      cycle0();
      chk("alias_data", rd0[95:64], 32'h5A5A1234);
      req0 = '0;
      cycle0();

      // Randomized traffic over aliased addresses; ungranted requests are held.
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < MP; p++) begin
            if (!req0[p] || last_g0[p]) begin
               w = int'($urandom_range(0, 31));
               k = int'($urandom_range(0, 3));
               a = 32'((w + k * MEMW) * 4 + int'($urandom_range(0, 3)));
               drive0(p, ($urandom_range(0, 3) != 0), a, $urandom_range(0, 1) == 1,
                      4'($urandom_range(0, 15)), $urandom);
            end
         end
         cycle0();
      end
      req0 = '0;
      cycle0();
      cycle0();

      // Stall generator on dut1.
      rst1 = 1'b0;
      lfsr_m = 16'hACE1;
      exp_rv1 = 1'b0;
      req1[0] = 1'b1;
      wen1[0] = 1'b0;
      be1[3:0] = 4'b0000;
      data1[31:0] = 32'hCAFEF00D;
      gcnt = 0;
      nonstall = 0;
      for (int c = 0; c < 200; c++) begin
         cycle1();
         if (!last_s1) nonstall++;
         if (obs_g1) gcnt++;
      end
      chk("grant_count", 32'(gcnt), 32'(nonstall));

      // Reset right after a grant.
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         cycle1();
         found = last_g1;
      end
      chk("find_grant", {31'd0, found}, 32'd1);
      rst1 = 1'b1;
      cycle1();
      chk("rst_rvalid_clr", {28'd0, rv1}, 32'd0);
      chk("rst_rdata_clr", rd1[31:0], 32'd0);
      rst1 = 1'b0;
      cycle1();
      chk("post_rst_gnt", {31'd0, obs_g1}, 32'd1);
      for (int c = 0; c < 40; c++) cycle1();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
